// File: rtl/disp_vram_rdslave.sv
// disp_vram_rdslave: AXI4 read-channel VRAM responder over a sideband-loaded word RAM.
// Defining VRSLV_LATENCY_EN inserts LATENCY wait cycles between AR handshake and first beat.
module disp_vram_rdslave #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic              ACLK,
    input  logic              ARSTN,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [31:0]       WDATA
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    state_t            state;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        len;
    logic [7:0]        cnt;
`ifdef VRSLV_LATENCY_EN
    logic [3:0]        wcnt;
`endif
    assign ARREADY = ARSTN && state == IDLE;
    assign RRESP   = 2'b00;
    always_ff @(posedge ACLK)
        if (WE) mem[WADDR] <= WDATA;
    always_ff @(posedge ACLK) begin
        if (!ARSTN) begin
            state  <= IDLE;
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            RDATA  <= '0;
            cnt    <= '0;
            len    <= '0;
            ptr    <= '0;
`ifdef VRSLV_LATENCY_EN
            wcnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (ARVALID) begin
                    len <= ARLEN;
                    ptr <= ARADDR[ADDR_W+1:2];
                    cnt <= '0;
`ifdef VRSLV_LATENCY_EN
                    wcnt  <= 4'(LATENCY - 1);
                    state <= WAIT;
`else
                    RDATA  <= mem[ARADDR[ADDR_W+1:2]];
                    RVALID <= 1'b1;
                    RLAST  <= ARLEN == 8'd0;
                    state  <= BURST;
`endif
                end
`ifdef VRSLV_LATENCY_EN
                WAIT: if (wcnt == 4'd0) begin
                    RDATA  <= mem[ptr];
                    RVALID <= 1'b1;
                    RLAST  <= len == 8'd0;
                    state  <= BURST;
                end else begin
                    wcnt <= wcnt - 4'd1;
                end
`endif
                BURST: if (RREADY) begin
                    if (cnt == len) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        // pointer wraps modulo memory depth
                        cnt   <= cnt + 8'd1;
                        ptr   <= ptr + 1'b1;
                        RDATA <= mem[ptr + 1'b1];
                        RLAST <= cnt + 8'd1 == len;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_vram_rdslave.sv
// tb_disp_vram_rdslave: directed self-checking bench for disp_vram_rdslave.
// Build with VRSLV_LATENCY_EN defined to exercise the wait-state scenario.
module tb_disp_vram_rdslave;
`ifdef VRSLV_LATENCY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif
    logic        ACLK = 0;
    logic        ARSTN = 0;
    logic [31:0] ARADDR = 0;
    logic [7:0]  ARLEN = 0;
    logic        ARVALID = 0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 0;
    logic        WE = 0;
    logic [11:0] WADDR = 0;
    logic [31:0] WDATA = 0;

    int checks = 0;
    int errors = 0;
    logic [31:0] bd[$];
    bit          bl[$];
    int          hold_err;
    int          cyc;
    bit          got;

    disp_vram_rdslave #(.ADDR_W(12), .LATENCY(4)) dut (
        .ACLK(ACLK), .ARSTN(ARSTN), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .WE(WE), .WADDR(WADDR), .WDATA(WDATA)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_mem(input logic [11:0] a, input logic [31:0] d);
        WE = 1; WADDR = a; WDATA = d;
        step();
        WE = 0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len);
        got = 0;
        ARADDR = addr; ARLEN = len; ARVALID = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = ARREADY;
            step();
        end
        ARVALID = 0;
    endtask

    // mode 0: RREADY always high; mode 1: RREADY pattern 1,0,0 repeating
    task automatic collect(input int mode, input int maxc);
        logic [31:0] pd;
        logic pl;
        bit pstall, done;
        bd.delete(); bl.delete();
        hold_err = 0; cyc = 0; done = 0; pstall = 0; pd = 0; pl = 0;
        for (int c = 0; c < maxc && !done; c++) begin
            RREADY = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (pstall && (RDATA !== pd || RLAST !== pl || RVALID !== 1'b1)) hold_err++;
            pstall = RVALID && !RREADY;
            pd = RDATA; pl = RLAST;
            if (RVALID && RREADY) begin
                bd.push_back(RDATA);
                bl.push_back(RLAST);
                done = RLAST;
            end
            cyc++;
            step();
        end
        RREADY = 0;
    endtask

    task automatic test_reset();
        ARSTN = 0;
        step();
        for (int i = 0; i < 8; i++) write_mem(12'(i), 32'h100 + i);
        write_mem(12'd8, 32'h200);
        write_mem(12'd4094, 32'hFFE);
        write_mem(12'd4095, 32'hFFF);
        checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", RVALID); end
        checks++; if (RLAST !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b exp 0", RLAST); end
        checks++; if (RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", RDATA); end
        checks++; if (ARREADY !== 1'b0) begin errors++; $display("FAIL rst_arready got %b exp 0", ARREADY); end
        checks++; if (RRESP !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b exp 00", RRESP); end
        ARSTN = 1;
        #1;
        checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL rst_release_arready got %b exp 1", ARREADY); end
        step();
    endtask

    task automatic test_burst8();
        do_ar(32'h0, 8'd7);
        checks++; if (!got) begin errors++; $display("FAIL t1_ar_timeout got 0 exp 1"); end
        collect(0, 40);
        checks++; if (bd.size() != 8) begin errors++; $display("FAIL t1_beats got %0d exp 8", bd.size()); end
        checks++; if (cyc != 8 + LAT) begin errors++; $display("FAIL t1_cycles got %0d exp %0d", cyc, 8 + LAT); end
        for (int i = 0; i < bd.size(); i++) begin
            checks++;
            if (bd[i] !== 32'h100 + i || bl[i] !== (i == 7)) begin
                errors++; $display("FAIL t1_beat%0d got %h/%b exp %h/%b", i, bd[i], bl[i], 32'h100 + i, i == 7);
            end
        end
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin errors++; $display("FAIL t1_after got rv=%b ar=%b exp rv=0 ar=1", RVALID, ARREADY); end
        step();
    endtask

    task automatic test_backpressure();
        do_ar(32'h0, 8'd7);
        collect(1, 60);
        checks++; if (bd.size() != 8) begin errors++; $display("FAIL t2_beats got %0d exp 8", bd.size()); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL t2_hold got %0d exp 0", hold_err); end
        for (int i = 0; i < bd.size(); i++) begin
            checks++;
            if (bd[i] !== 32'h100 + i || bl[i] !== (i == 7)) begin
                errors++; $display("FAIL t2_beat%0d got %h/%b exp %h/%b", i, bd[i], bl[i], 32'h100 + i, i == 7);
            end
        end
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hFFE; exp_d[1] = 32'hFFF; exp_d[2] = 32'h100; exp_d[3] = 32'h101;
        do_ar(32'h0000_3FF8, 8'd3);
        collect(0, 40);
        checks++; if (bd.size() != 4) begin errors++; $display("FAIL t3_beats got %0d exp 4", bd.size()); end
        for (int i = 0; i < bd.size() && i < 4; i++) begin
            checks++;
            if (bd[i] !== exp_d[i] || bl[i] !== (i == 3)) begin
                errors++; $display("FAIL t3_beat%0d got %h/%b exp %h/%b", i, bd[i], bl[i], exp_d[i], i == 3);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int k;
        RREADY = 1;
        ARADDR = 32'h20; ARLEN = 8'd0; ARVALID = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            got = ARREADY;
            step();
        end
        checks++; if (!got) begin errors++; $display("FAIL t4_ar_timeout got 0 exp 1"); end
        k = 1;
        while (!RVALID && k < 20) begin step(); k++; end
        checks++; if (RDATA !== 32'h200 || RLAST !== 1'b1) begin errors++; $display("FAIL t4_single got %h/%b exp 00000200/1", RDATA, RLAST); end
        while (!ARREADY && k < 20) begin step(); k++; end
        checks++; if (k != 2 + LAT) begin errors++; $display("FAIL t4_gap got %0d exp %0d", k, 2 + LAT); end
        step();
        ARVALID = 0;
        k = 0;
        while (!RVALID && k < 20) begin step(); k++; end
        checks++; if (RDATA !== 32'h200 || RLAST !== 1'b1) begin errors++; $display("FAIL t4_second got %h/%b exp 00000200/1", RDATA, RLAST); end
        step();
        RREADY = 0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_ar(32'h0, 8'd7);
        RREADY = 1;
        for (int i = 0; i < 20 && !RVALID; i++) step();
        step(); step();
        checks++; if (RDATA !== 32'h102 || RVALID !== 1'b1) begin errors++; $display("FAIL t5_beat3 got %h/%b exp 00000102/1", RDATA, RVALID); end
        ARSTN = 0;
        step();
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin errors++; $display("FAIL t5_in_reset got rv=%b ar=%b exp 0/0", RVALID, ARREADY); end
        step();
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin errors++; $display("FAIL t5_in_reset2 got rv=%b ar=%b exp 0/0", RVALID, ARREADY); end
        ARSTN = 1;
        #1;
        checks++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin errors++; $display("FAIL t5_release got ar=%b rv=%b exp 1/0", ARREADY, RVALID); end
        RREADY = 0;
        do_ar(32'h0, 8'd1);
        collect(0, 40);
        checks++; if (bd.size() != 2 || bd[0] !== 32'h100) begin errors++; $display("FAIL t5_new_burst got n=%0d d0=%h exp 2/00000100", bd.size(), bd.size() ? bd[0] : 32'h0); end
        step();
    endtask

`ifdef VRSLV_LATENCY_EN
    task automatic test_latency();
        int k;
        do_ar(32'h8, 8'd0);
        k = 0;
        while (!RVALID && k < 20) begin step(); k++; end
        checks++; if (k != 4) begin errors++; $display("FAIL t6_latency got %0d exp 4", k); end
        RREADY = 1; step(); RREADY = 0; step();
        do_ar(32'h8, 8'd0);
        step(); step(); step();
        write_mem(12'd2, 32'hA2);
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'h102) begin errors++; $display("FAIL t6_issue_write got %b/%h exp 1/00000102", RVALID, RDATA); end
        RREADY = 1; step(); RREADY = 0; step();
        do_ar(32'h8, 8'd0);
        step(); step();
        write_mem(12'd2, 32'hB2);
        step();
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'hB2) begin errors++; $display("FAIL t6_early_write got %b/%h exp 1/000000b2", RVALID, RDATA); end
        RREADY = 1; step(); RREADY = 0; step();
    endtask
`endif

    initial begin
        test_reset();
        test_burst8();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef VRSLV_LATENCY_EN
        test_latency();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
